// File: rtl/op_pkg.sv
// ============================================================================
// op_pkg : opcode / control-word constants and the shared encode function
// Revision: 1.0
// ============================================================================
`default_nettype none

package op_pkg;

  localparam logic [4:0] OP_ADDI  = 5'b11000;
  localparam logic [4:0] OP_SUBI  = 5'b11001;
  localparam logic [4:0] OP_LW    = 5'b11010;
  localparam logic [4:0] OP_SW    = 5'b11011;
  localparam logic [4:0] OP_BEQ   = 5'b11100;
  localparam logic [4:0] OP_BNE   = 5'b11101;
  localparam logic [4:0] OP_J     = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00111;
  localparam logic [1:0] OP_RPFX0 = 2'b01;
  localparam logic [1:0] OP_RPFX1 = 2'b10;

  // {memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop[1:0]}
  localparam logic [8:0] CW_ADDI  = 9'b000101000;
  localparam logic [8:0] CW_SUBI  = 9'b000101011;
  localparam logic [8:0] CW_LW    = 9'b100101000;
  localparam logic [8:0] CW_SW    = 9'b010100000;
  localparam logic [8:0] CW_BEQ   = 9'b001000011;
  localparam logic [8:0] CW_BNE   = 9'b000000011;
  localparam logic [8:0] CW_JMP   = 9'b000000100;
  localparam logic [8:0] CW_RTYPE = 9'b000011010;

  // Returns {legal, opcode}; unknown words fall to the default arm and read as illegal.
  function automatic logic [5:0] encode_ctrl(input logic [8:0] ctrl,
                                             input logic [3:0] rsub,
                                             input logic       link);
    logic [5:0] res;
    res = '0;
    case (ctrl)
      CW_ADDI:  res = {1'b1, OP_ADDI};
      CW_SUBI:  res = {1'b1, OP_SUBI};
      CW_LW:    res = {1'b1, OP_LW};
      CW_SW:    res = {1'b1, OP_SW};
      CW_BEQ:   res = {1'b1, OP_BEQ};
      CW_BNE:   res = {1'b1, OP_BNE};
      CW_JMP:   res = {1'b1, (link ? OP_JAL : OP_J)};
      CW_RTYPE: res = {1'b1, (rsub[3] ? OP_RPFX1 : OP_RPFX0), rsub[2:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/op_fifo.sv
// ============================================================================
// op_fifo : parameterised synchronous FIFO, occupancy-tracked, zero when empty
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
      else if (w_do_pop && !w_do_push) r_level <= r_level - LW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/op_encoder.sv
// ============================================================================
// op_encoder : control word -> opcode encoder with output FIFO and error count
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_encoder #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8:0]                   in_ctrl,
  input  logic [3:0]                   in_rsub,
  input  logic                         in_link,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   out_op,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err,
  output logic [ERRW-1:0]              err_cnt
);

  import op_pkg::*;

  logic            w_legal;
  logic [4:0]      w_op;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            r_err;
  logic [ERRW-1:0] r_err_cnt;

  assign {w_legal, w_op} = encode_ctrl(in_ctrl, in_rsub, in_link);

  assign in_ready  = !w_full;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

  op_fifo #(
    .WIDTH (5),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_op),
    .pop   (w_pop),
    .rdata (out_op),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_op_encoder.sv
// ============================================================================
// tb_op_encoder : scoreboard bench for op_encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_op_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_ctrl = '0;
  logic [3:0] in_rsub = '0;
  logic       in_link = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_op;
  logic [2:0] level;
  logic       err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  logic [8:0] cw_tab [6] = '{9'b000101000, 9'b000101011, 9'b100101000,
                             9'b010100000, 9'b001000011, 9'b000000011};
  logic [4:0] op_tab [6] = '{5'b11000, 5'b11001, 5'b11010,
                             5'b11011, 5'b11100, 5'b11101};

  op_encoder #(.DEPTH(4), .ERRW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rsub   (in_rsub),
    .in_link   (in_link),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .level     (level),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase after the accept edge.
  task automatic send(input logic [8:0] c, input logic [3:0] rs, input logic lk,
                      input logic legal, input logic [4:0] op);
    int waited = 0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_rsub  = rs;
    in_link  = lk;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (legal) exp_q.push_back(op);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (level != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_level", 32'(level), 0);
    out_ready = 1'b0;
  endtask

  // Consumer side: inputs move only just after rising edges, so the falling edge is stable.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pop_underflow", 32'(exp_q.size()), 1);
      else                   check("out_op", 32'(out_op), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #22;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_op",    32'(out_op),    0);
    check("rst_level",     32'(level),     0);
    check("rst_err",       32'(err),       0);
    check("rst_err_cnt",   32'(err_cnt),   0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Streaming legal words with one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(cw_tab[i], 4'h0, 1'b0, 1'b1, op_tab[i]);
      check("lat_valid", 32'(out_valid), 1);
      check("lat_op",    32'(out_op),    32'(op_tab[i]));
    end
    send(9'b000000100, 4'h0, 1'b0, 1'b1, 5'b00000);
    send(9'b000000100, 4'h0, 1'b1, 1'b1, 5'b00111);
    send(9'b000011010, 4'b0101, 1'b0, 1'b1, 5'b01101);
    send(9'b000011010, 4'b1011, 1'b0, 1'b1, 5'b10011);
    drain();

    // Fill to full, then pop with a push offered in the same cycle
    for (int i = 0; i < 4; i++) send(cw_tab[i], 4'h0, 1'b0, 1'b1, op_tab[i]);
    check("full_level", 32'(level),    4);
    check("full_ready", 32'(in_ready), 0);
    in_valid  = 1'b1;
    in_ctrl   = cw_tab[4];
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_level",  32'(level),    3);
    check("ready_back", 32'(in_ready), 1);
    @(posedge clk);
    exp_q.push_back(op_tab[4]);
    #1;
    in_valid = 1'b0;
    check("refill_level", 32'(level), 4);
    drain();

    // Illegal words: no FIFO write, one-cycle err, saturating count
    send(9'b111111111, 4'h0, 1'b0, 1'b0, 5'h00);
    check("ill_err",     32'(err),       1);
    check("ill_cnt",     32'(err_cnt),   1);
    check("ill_nowrite", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("ill_err_pulse", 32'(err), 0);
    for (int i = 0; i < 260; i++) send(9'b111111111, 4'h0, 1'b0, 1'b0, 5'h00);
    check("ill_sat", 32'(err_cnt), 255);
    check("ill_sat_level", 32'(level), 0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) send(cw_tab[i+1], 4'h0, 1'b0, 1'b1, op_tab[i+1]);
    check("pre_rst_level", 32'(level), 3);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_op",    32'(out_op),    0);
    check("arst_level",     32'(level),     0);
    check("arst_in_ready",  32'(in_ready),  1);
    check("arst_err_cnt",   32'(err_cnt),   0);
    exp_q.delete();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    send(cw_tab[5], 4'h0, 1'b0, 1'b1, op_tab[5]);
    check("post_rst_level", 32'(level),  1);
    check("post_rst_op",    32'(out_op), 32'(op_tab[5]));
    drain();

    @(posedge clk); #1;
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/op_encoder.md
Name: op_encoder

Overview:
- Inverse of the controller's main decoder: accepts a 9-bit control word {memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop[1:0]} and produces the 5-bit opcode that decodes back to that word.
- Used by the instruction-stream builder and by test harnesses to emit opcodes into instruction memory.
- Requests arrive on a valid/ready input; opcodes are buffered in a small FIFO and drained on a valid/ready output.
- Control words with no opcode are rejected and counted.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
ERRW, 8, width of the saturating illegal-word counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready at clk edge
in_ctrl  input  9  control word to encode
in_rsub  input  4  R-type sub-select; bit3 picks prefix, bits2:0 are op[2:0]
in_link  input  1  chooses JAL over J when in_ctrl is the jump word
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head when out_valid & out_ready
out_op  output  5  opcode at FIFO head; 0 when empty
level  output  $clog2(DEPTH+1)  current FIFO occupancy
err  output  1  one-cycle pulse: illegal word accepted
err_cnt  output  ERRW  saturating count of illegal words

Behaviour:
- Reset (async, any time, including mid-transfer) clears the FIFO and drives these values:
  - in_ready=1, out_valid=0, out_op=0, level=0, err=0, err_cnt=0.
  - Pointers are zeroed. Deassertion is used synchronously.
- Encode table (combinational, in_ctrl -> op):
  - 000101000 -> 11000 ADDI
  - 000101011 -> 11001 SUBI
  - 100101000 -> 11010 LW
  - 010100000 -> 11011 SW
  - 001000011 -> 11100 BEQ
  - 000000011 -> 11101 BNE
  - 000000100 -> 00111 (JAL) if in_link, else 00000 (J)
  - 000011010 -> R-type: {in_rsub[3] ? 2'b10 : 2'b01, in_rsub[2:0]}
  - any other word -> illegal
- in_ready = !full. It is independent of in_ctrl legality.
- Legal accepted word: written to the FIFO at the accept edge. out_valid is high after that edge, so latency is 1 cycle when the FIFO was empty.
- Illegal accepted word:
  - Not written to the FIFO.
  - err is high for exactly the cycle after the accept edge.
  - err_cnt increments and holds at 2^ERRW-1.
- Pop: when out_valid & out_ready at an edge, the head advances. out_op shows the next entry, or 0 when empty.
- Simultaneous push and pop in one cycle (FIFO not full): both occur and level is unchanged.
- Full: in_ready=0, so no push happens even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0, and out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level, which ranges 0..DEPTH.
- No X is ever driven on outputs, including for undefined in_ctrl bit patterns, which count as illegal.
- in_valid=0 means no state change on the input side. in_ctrl, in_rsub and in_link are don't-care at that time.

Decomposition:
- Package op_pkg:
  - opcode localparams: OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RPFX0=2'b01, OP_RPFX1=2'b10.
  - control-word localparams: CW_ADDI, CW_SUBI, CW_LW, CW_SW, CW_BEQ, CW_BNE, CW_JMP, CW_RTYPE.
  - The decoder shares the same package.
- Sub-module op_fifo: a parameterised synchronous FIFO with width, depth, push, pop, full, empty and level. The top holds the encode logic and error counter.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, out_op=0, level=0, err_cnt=0.
- Sequence ADDI, SUBI, LW, SW, BEQ, BNE control words with out_ready=1: out_op sequence is 11000, 11001, 11010, 11011, 11100, 11101, each 1 cycle after accept.
- Jump word 000000100 with in_link=0 then in_link=1: out_op 00000 then 00111. R-type word with in_rsub=4'b0101 gives 01101; with 4'b1011 gives 10011.
- Fill with out_ready=0 using 5 legal pushes:
  - Push 4 is accepted, level=4, in_ready=0, and the 5th is stalled.
  - Pop one with a simultaneous push offered: the push is not taken that cycle and is taken next cycle.
  - Order is preserved and the pointers wrap correctly after 2*DEPTH operations.
- Illegal word 111111111: no FIFO write, err pulse for 1 cycle, err_cnt=1. 260 illegal words with ERRW=8 gives err_cnt=255.
- Assert reset asynchronously mid-cycle with 3 entries queued: outputs go to reset values immediately without a clock edge. After release, the first new push appears alone at out_op.
